// File: rtl/ntcrack_host_link_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntcrack_host_link_if                                                  |
// | Host byte streams plus cracker hash/password signals.                 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface ntcrack_host_link_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] new_hash_byte;
  logic       store_hash_byte;
  logic       go;
  logic       match_found;
  logic       your_turn;
  logic [7:0] password_byte;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport slave (
    input  in_data, in_valid, match_found, your_turn, password_byte, out_ready,
    output in_ready, new_hash_byte, store_hash_byte, go, out_data, out_valid, busy
  );

  modport master (
    output in_data, in_valid, match_found, your_turn, password_byte, out_ready,
    input  in_ready, new_hash_byte, store_hash_byte, go, out_data, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/ntcrack_host_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntcrack_host_link                                                     |
// | Loads a 16-byte hash into the cracker, returns password + newline.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ntcrack_host_link (
  input  wire logic          clk,
  input  wire logic          rst,
  ntcrack_host_link_if.slave link
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_SEND    = 3'd4,
    S_TERM    = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] load_cnt_q, load_cnt_d;
  logic [4:0] len_q, len_d;
  logic [4:0] rd_idx_q, rd_idx_d;
  logic [7:0] hash_byte_q, hash_byte_d;
  logic       store_q, store_d;
  logic       go_q, go_d;
  logic [7:0] pw_mem_q [16];
  logic       mem_we;
  logic       w_accept;
  logic       w_capture;

  assign w_accept  = link.in_valid && (state_q == S_LOAD);
  // A strobe arriving together with match_found in WAIT is the first password byte.
  assign w_capture = link.your_turn &&
                     ((state_q == S_COLLECT) || ((state_q == S_WAIT) && link.match_found));

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    len_d       = len_q;
    rd_idx_d    = rd_idx_q;
    hash_byte_d = hash_byte_q;
    store_d     = 1'b0;
    go_d        = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (w_accept) begin
          hash_byte_d = link.in_data;
          store_d     = 1'b1;
          load_cnt_d  = load_cnt_q + 5'd1;
          if (load_cnt_q == 5'd15) state_d = S_START;
        end
      end
      S_START: begin
        go_d    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (link.match_found) state_d = S_COLLECT;
      end
      S_COLLECT: ;
      S_SEND: begin
        if (link.out_ready) begin
          if (rd_idx_q == len_q - 5'd1) begin
            rd_idx_d = 5'd0;
            state_d  = S_TERM;
          end else begin
            rd_idx_d = rd_idx_q + 5'd1;
          end
        end
      end
      S_TERM: begin
        if (link.out_ready) begin
          state_d    = S_LOAD;
          load_cnt_d = 5'd0;
          len_d      = 5'd0;
          rd_idx_d   = 5'd0;
        end
      end
      default: state_d = S_LOAD;
    endcase

    // A 0x00 terminator is never stored; an empty password skips SEND.
    if (w_capture) begin
      if (link.password_byte == 8'h00) begin
        state_d = (len_q == 5'd0) ? S_TERM : S_SEND;
      end else begin
        mem_we = 1'b1;
        len_d  = len_q + 5'd1;
        if (len_q == 5'd15) state_d = S_SEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= 5'd0;
      len_q       <= 5'd0;
      rd_idx_q    <= 5'd0;
      hash_byte_q <= 8'h00;
      store_q     <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      len_q       <= len_d;
      rd_idx_q    <= rd_idx_d;
      hash_byte_q <= hash_byte_d;
      store_q     <= store_d;
      go_q        <= go_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) pw_mem_q[len_q[3:0]] <= link.password_byte;
  end

  // Outputs are gated by rst so an asserted reset silences the link at once.
  assign link.in_ready        = !rst && (state_q == S_LOAD);
  assign link.busy            = !rst && (state_q != S_LOAD);
  assign link.out_valid       = !rst && ((state_q == S_SEND) || (state_q == S_TERM));
  assign link.store_hash_byte = !rst && store_q;
  assign link.go              = !rst && go_q;
  assign link.new_hash_byte   = hash_byte_q;
  assign link.out_data        = rst                  ? 8'h00 :
                                (state_q == S_SEND)  ? pw_mem_q[rd_idx_q[3:0]] :
                                (state_q == S_TERM)  ? 8'h0A : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ntcrack_host_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ntcrack_host_link                                                  |
// | Scoreboard bench for hash load, password return and reset abort.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ntcrack_host_link;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntcrack_host_link_if dif ();
  ntcrack_host_link dut (.clk(clk), .rst(rst), .link(dif));

  int vecs = 0;
  int errs = 0;
  int go_cnt = 0;
  logic [7:0] exp_store [$];
  logic [7:0] exp_out [$];
  logic [7:0] last_hash = 8'h00;
  logic [7:0] held_data = 8'h00;
  logic       stalled = 1'b0;

  // Monitor: pops scoreboards on store strobes and output handshakes.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      last_hash = 8'h00;
      stalled   = 1'b0;
    end else begin
      if (dif.store_hash_byte) begin
        vecs++;
        if (dif.go) begin
          errs++;
          $display("FAIL store_go_overlap: go=%b store=%b required not both high", dif.go, dif.store_hash_byte);
        end
        if (exp_store.size() == 0) begin
          errs++;
          $display("FAIL unexpected_store: got byte %h, none expected", dif.new_hash_byte);
        end else begin
          e = exp_store.pop_front();
          if (dif.new_hash_byte !== e) begin
            errs++;
            $display("FAIL store_byte: got %h expected %h", dif.new_hash_byte, e);
          end
        end
        last_hash = dif.new_hash_byte;
      end else begin
        vecs++;
        if (dif.new_hash_byte !== last_hash) begin
          errs++;
          $display("FAIL hash_hold: got %h expected %h", dif.new_hash_byte, last_hash);
        end
      end
      if (dif.go) go_cnt++;
      if (dif.out_valid) begin
        if (stalled) begin
          vecs++;
          if (dif.out_data !== held_data) begin
            errs++;
            $display("FAIL out_stable: got %h expected %h", dif.out_data, held_data);
          end
        end
        if (dif.out_ready) begin
          stalled = 1'b0;
          vecs++;
          if (exp_out.size() == 0) begin
            errs++;
            $display("FAIL unexpected_out: got %h, none expected", dif.out_data);
          end else begin
            e = exp_out.pop_front();
            if (dif.out_data !== e) begin
              errs++;
              $display("FAIL out_byte: got %h expected %h", dif.out_data, e);
            end
          end
        end else begin
          stalled   = 1'b1;
          held_data = dif.out_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    vecs++;
    if ({dif.store_hash_byte, dif.go, dif.out_valid, dif.in_ready, dif.busy} !== 5'b0 ||
        dif.new_hash_byte !== 8'h00 || dif.out_data !== 8'h00) begin
      errs++;
      $display("FAIL %s: st=%b go=%b ov=%b ir=%b busy=%b nh=%h od=%h required all zero",
               tag, dif.store_hash_byte, dif.go, dif.out_valid, dif.in_ready, dif.busy,
               dif.new_hash_byte, dif.out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    sync();
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0) begin
      errs++;
      $display("FAIL post_reset: in_ready=%b busy=%b required 1/0", dif.in_ready, dif.busy);
    end
  endtask

  task automatic feed_hash(input logic [7:0] base, input int n);
    int g0;
    g0 = go_cnt;
    sync();
    for (int i = 0; i < n; i++) begin
      dif.in_valid = 1'b1;
      dif.in_data  = base + 8'(i);
      exp_store.push_back(base + 8'(i));
      @(negedge clk);
      vecs++;
      if (dif.in_ready !== 1'b1) begin
        errs++;
        $display("FAIL load_ready: byte %0d in_ready=%b required 1", i, dif.in_ready);
      end
      sync();
    end
    dif.in_valid = 1'b0;
    if (n == 16) begin
      @(negedge clk);
      vecs++;
      if (dif.go !== 1'b0 || dif.in_ready !== 1'b0 || dif.busy !== 1'b1) begin
        errs++;
        $display("FAIL last_store_cycle: go=%b in_ready=%b busy=%b required 0/0/1", dif.go, dif.in_ready, dif.busy);
      end
      @(negedge clk);
      vecs++;
      if (dif.go !== 1'b1) begin
        errs++;
        $display("FAIL go_timing: go=%b required 1 one cycle after last store", dif.go);
      end
      @(negedge clk);
      vecs++;
      if (dif.go !== 1'b0 || go_cnt - g0 != 1) begin
        errs++;
        $display("FAIL go_pulse: go=%b pulses=%0d required 0 and 1 pulse", dif.go, go_cnt - g0);
      end
      vecs++;
      if (exp_store.size() != 0) begin
        errs++;
        $display("FAIL store_count: %0d stores missing, required 0", exp_store.size());
      end
    end
  endtask

  task automatic strobe(input logic [7:0] b, input logic mf);
    dif.match_found   = mf;
    dif.your_turn     = 1'b1;
    dif.password_byte = b;
    sync();
    dif.your_turn     = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    for (int i = 0; i < 300 && exp_out.size() != 0; i++) begin
      if (toggle) dif.out_ready = ~dif.out_ready;
      sync();
    end
    vecs++;
    if (exp_out.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_out.size());
      exp_out.delete();
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0 || dif.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL job_end: in_ready=%b busy=%b out_valid=%b required 1/0/0", dif.in_ready, dif.busy, dif.out_valid);
    end
    dif.match_found = 1'b0;
  endtask

  task automatic test_collect();
    feed_hash(8'h00, 16);
    sync();
    dif.out_ready = 1'b1;
    strobe(8'h55, 1'b0);
    exp_out.push_back(8'h61); exp_out.push_back(8'h62);
    exp_out.push_back(8'h63); exp_out.push_back(8'h0A);
    strobe(8'h61, 1'b1);
    strobe(8'h62, 1'b1);
    strobe(8'h63, 1'b1);
    strobe(8'h00, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_overflow();
    feed_hash(8'h20, 16);
    sync();
    dif.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_out.push_back(8'h41);
    exp_out.push_back(8'h0A);
    for (int i = 0; i < 17; i++) strobe(8'h41, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_zero_first();
    feed_hash(8'h30, 16);
    sync();
    dif.out_ready = 1'b1;
    exp_out.push_back(8'h0A);
    strobe(8'h00, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    feed_hash(8'h40, 16);
    sync();
    dif.out_ready = 1'b0;
    exp_out.push_back(8'h11); exp_out.push_back(8'h22);
    exp_out.push_back(8'h33); exp_out.push_back(8'h44);
    exp_out.push_back(8'h0A);
    strobe(8'h11, 1'b1);
    strobe(8'h22, 1'b1);
    strobe(8'h33, 1'b1);
    strobe(8'h44, 1'b1);
    strobe(8'h00, 1'b1);
    drain(1'b1);
  endtask

  task automatic test_reset_abort();
    feed_hash(8'h80, 8);
    sync();
    rst = 1'b1;
    sync();
    @(negedge clk);
    check_reset_outputs("abort_reset");
    vecs++;
    if (exp_store.size() != 0) begin
      errs++;
      $display("FAIL abort_stores: %0d stores missing, required 0", exp_store.size());
    end
    sync();
    rst = 1'b0;
    feed_hash(8'hF0, 16);
    sync();
    dif.out_ready = 1'b1;
    exp_out.push_back(8'h0A);
    strobe(8'h00, 1'b1);
    drain(1'b0);
  endtask

  initial begin
    dif.in_data       = 8'h00;
    dif.in_valid      = 1'b0;
    dif.match_found   = 1'b0;
    dif.your_turn     = 1'b0;
    dif.password_byte = 8'h00;
    dif.out_ready     = 1'b1;
    test_reset();
    test_collect();
    test_overflow();
    test_zero_first();
    test_backpressure();
    test_reset_abort();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntcrack_host_link.md
NTCRACK_HOST_LINK -- requirements
Module: ntcrack_host_link

Interface
REQ-001 SHALL have ports: clk  input  1  single clock for all logic (rising edge).
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_data  input  8  hash byte from host byte stream.
REQ-004 SHALL have ports: in_valid  input  1  in_data valid.
REQ-005 SHALL have ports: in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-006 SHALL have ports: new_hash_byte  output  8  hash byte to cracker.
REQ-007 SHALL have ports: store_hash_byte  output  1  one-cycle strobe; cracker stores new_hash_byte.
REQ-008 SHALL have ports: go  output  1  one-cycle start strobe to cracker.
REQ-009 SHALL have ports: match_found  input  1  cracker found the password.
REQ-010 SHALL have ports: your_turn  input  1  one-cycle strobe; password_byte valid this cycle.
REQ-011 SHALL have ports: password_byte  input  8  password byte from cracker.
REQ-012 SHALL have ports: out_data  output  8  result byte to host byte stream.
REQ-013 SHALL have ports: out_valid  output  1  out_data valid.
REQ-014 SHALL have ports: out_ready  input  1  host accepts when out_valid && out_ready.
REQ-015 SHALL have ports: busy  output  1  high in every state except LOAD.

Function
REQ-016 SHALL implement FSM states LOAD, START, WAIT, COLLECT, SEND, TERM.
REQ-017 In LOAD: in_ready=1; each accepted byte at cycle N appears on new_hash_byte with store_hash_byte=1 at N+1; a 5-bit load counter increments.
REQ-018 Hash order: first accepted byte is hash byte 0, 16th accepted is byte 15; exactly 16 stores per job.
REQ-019 On the 16th accept: LOAD->START; in_ready=0 from the next cycle; START drives go=1 for exactly one cycle (the cycle after the 16th store strobe), then ->WAIT.
REQ-020 go and store_hash_byte SHALL never be high in the same cycle; new_hash_byte holds its last value when not strobing.
REQ-021 WAIT: on match_found=1 ->COLLECT; a your_turn strobe in that same cycle SHALL be captured as byte 0.
REQ-022 WAIT/START: your_turn without match_found SHALL be ignored.
REQ-023 COLLECT: each your_turn strobe writes password_byte into a 16x8 buffer at index = 5-bit length counter, then increments the counter.
REQ-024 COLLECT ends (->SEND) when a captured byte is 0x00 (not stored, counter unchanged) or when the counter reaches 16; strobes after that SHALL be ignored.
REQ-025 SEND: emits buffer[0..len-1] in order; out_valid=1; out_data stable while out_valid && !out_ready; advance only on handshake.
REQ-026 len=0: SEND is skipped; go directly to TERM.
REQ-027 TERM: emits 0x0A once via the same handshake, then ->LOAD with counters cleared.
REQ-028 out_valid=0 in LOAD, START, WAIT, COLLECT; in_ready=0 outside LOAD.
REQ-029 match_found held high after leaving WAIT SHALL NOT retrigger capture.

Reset
REQ-030 While rst=1 at a clock edge: state=LOAD; counters=0; store_hash_byte=0, go=0, out_valid=0, in_ready=0, busy=0, new_hash_byte=0x00, out_data=0x00.
REQ-031 First cycle after rst deasserts: in_ready=1.
REQ-032 rst mid-job (any state) SHALL abort immediately; no further go/store/out_valid; partial hash or password is discarded.
REQ-033 Buffer contents need no reset; length counter gates all reads.

Verification
REQ-034 Reset, feed 16 bytes 0x00..0x0F back-to-back -> 16 store strobes with bytes 0x00..0x0F in order on consecutive cycles, go=1 exactly one cycle after the last, busy=1.
REQ-035 After go, match_found=1 and your_turn strobes 0x61,0x62,0x63,0x00 with out_ready=1 -> out stream 0x61,0x62,0x63,0x0A; then in_ready=1.
REQ-036 17 your_turn strobes 0x41 with no 0x00 -> exactly 16 bytes 0x41 then 0x0A; 17th strobe ignored.
REQ-037 First captured byte 0x00 -> single output 0x0A.
REQ-038 out_ready toggled 0/1 every cycle during SEND -> each byte held stable until accepted; no byte lost or duplicated.
REQ-039 rst pulsed after 8 hash bytes, then 16 new bytes 0xF0..0xFF -> exactly 16 stores 0xF0..0xFF, one go; no store from the aborted job.
